id_ex_pipe_stage: RTL and testbench

- Parametrised successor to the plain ID/EX latch.
- Adds valid/ready flow control, flush (bubble insertion) and an optional 1-entry skid buffer, so the stage can stall without a combinational ready path back into decode.
- Sits between the decode/register-read stage and the EX stage.
- Also provides occupancy and saturating bubble-count outputs for debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 36 +++
 rtl/id_ex_pipe_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and payload layout for the ID/EX pipeline stage.
package pipe_pkg;

  localparam int unsigned DEF_WB_W   = 2;
  localparam int unsigned DEF_MEM_W  = 3;
  localparam int unsigned DEF_EX_W   = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_R_W    = 5;

  localparam int unsigned DEF_CTRL_W = DEF_WB_W + DEF_MEM_W + DEF_EX_W;
  localparam int unsigned DEF_BODY_W = 3 * DEF_DATA_W + 3 * DEF_R_W;

  // Field order matches the ctrl/body packing used by id_ex_pipe_stage.
  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb_ctrl;
    logic [DEF_MEM_W-1:0]  mem_ctrl;
    logic [DEF_EX_W-1:0]   ex_ctrl;
    logic [DEF_DATA_W-1:0] data1;
    logic [DEF_DATA_W-1:0] data2;
    logic [DEF_DATA_W-1:0] extended;
    logic [DEF_R_W-1:0]    rs;
    logic [DEF_R_W-1:0]    rt;
    logic [DEF_R_W-1:0]    rd;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid + payload register; clearing drops valid and zeroes the control
// field while the data body keeps its last value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned BODY_W = DEF_BODY_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [BODY_W-1:0] d_body,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [BODY_W-1:0] body
);

  // Falling-edge capture; clear wins over load.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
      ctrl  <= '0;
      body  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      body  <= d_body;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready flow control, flush and an
// optional skid entry so ready_d can come straight from a flop.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WB_W    = DEF_WB_W,
  parameter int unsigned MEM_W   = DEF_MEM_W,
  parameter int unsigned EX_W    = DEF_EX_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned R_W     = DEF_R_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_d,
  output logic              ready_d,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   wb_ctrl_d,
  input  logic [MEM_W-1:0]  mem_ctrl_d,
  input  logic [EX_W-1:0]   ex_ctrl_d,
  input  logic [DATA_W-1:0] data1_d,
  input  logic [DATA_W-1:0] data2_d,
  input  logic [DATA_W-1:0] extended_d,
  input  logic [R_W-1:0]    rs_d,
  input  logic [R_W-1:0]    rt_d,
  input  logic [R_W-1:0]    rd_d,
  output logic              valid_q,
  input  logic              ready_q,
  output logic [WB_W-1:0]   wb_ctrl_q,
  output logic [MEM_W-1:0]  mem_ctrl_q,
  output logic [EX_W-1:0]   ex_ctrl_q,
  output logic [DATA_W-1:0] data1_q,
  output logic [DATA_W-1:0] data2_q,
  output logic [DATA_W-1:0] extended_q,
  output logic [R_W-1:0]    rs_q,
  output logic [R_W-1:0]    rt_q,
  output logic [R_W-1:0]    rd_q,
  output logic [1:0]        occ_q,
  output logic [CNT_W-1:0]  bubble_cnt_q
);

  localparam int unsigned CW = WB_W + MEM_W + EX_W;
  localparam int unsigned BW = 3 * DATA_W + 3 * R_W;

  logic [CW-1:0] in_ctrl, main_d_ctrl, main_ctrl, skid_ctrl;
  logic [BW-1:0] in_body, main_d_body, main_body, skid_body;
  logic          skid_valid;
  logic          acc, main_free;
  logic          main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic          nxt_main_v, nxt_skid_v;

  assign in_ctrl = {wb_ctrl_d, mem_ctrl_d, ex_ctrl_d};
  assign in_body = {data1_d, data2_d, extended_d, rs_d, rt_d, rd_d};

  assign {wb_ctrl_q, mem_ctrl_q, ex_ctrl_q} = main_ctrl;
  assign {data1_q, data2_q, extended_q, rs_q, rt_q, rd_q} = main_body;

  assign acc       = valid_d & ready_d;
  assign main_free = ~valid_q | ready_q;

  // Slot steering: flush first, then refill main (skid before new input),
  // otherwise park the new input in the skid.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        if (acc) skid_load = 1'b1;
        else     skid_clr  = 1'b1;
      end else if (acc) begin
        main_load = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end else if (acc) begin
      skid_load = 1'b1;
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_body = main_from_skid ? skid_body : in_body;

  pipe_slot #(.CTRL_W(CW), .BODY_W(BW)) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (main_load),
    .clr     (main_clr),
    .d_ctrl  (main_d_ctrl),
    .d_body  (main_d_body),
    .valid   (valid_q),
    .ctrl    (main_ctrl),
    .body    (main_body)
  );

  // Skid entry and ready source depend on the build flavour.
  if (SKID_EN) begin : g_skid
    pipe_slot #(.CTRL_W(CW), .BODY_W(BW)) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (skid_load),
      .clr     (skid_clr),
      .d_ctrl  (in_ctrl),
      .d_body  (in_body),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .body    (skid_body)
    );
    assign ready_d = ~skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_body  = '0;
    assign ready_d    = ~valid_q | ready_q;
  end

  assign nxt_main_v = main_clr ? 1'b0 : (main_load ? 1'b1 : valid_q);
  assign nxt_skid_v = skid_clr ? 1'b0 : (skid_load ? 1'b1 : skid_valid);

  // Occupancy tracks the valids on the same edge.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) occ_q <= 2'd0;
    else          occ_q <= 2'({1'b0, nxt_main_v}) + 2'({1'b0, nxt_skid_v});
  end

  // Saturating count of cycles where downstream was ready but got nothing.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      bubble_cnt_q <= '0;
    else if (!valid_q && ready_q && !(&bubble_cnt_q))
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: scoreboard on the default build plus directed
// checks on a no-skid build and a 4-bit bubble counter build.
module tb_id_ex_pipe_stage;
  import pipe_pkg::*;

  logic clk, rst_n;
  logic valid_d, flush, ready_q;
  id_ex_payload_t drv;

  // default build outputs
  logic        ready_d, valid_q;
  logic [1:0]  wb_q;
  logic [2:0]  mem_q;
  logic [3:0]  ex_q;
  logic [31:0] d1_q, d2_q, ext_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [1:0]  occ_q;
  logic [15:0] bub_q;
  id_ex_payload_t got;
  assign got = {wb_q, mem_q, ex_q, d1_q, d2_q, ext_q, rs_q, rt_q, rd_q};

  // no-skid build
  logic        valid2, ready_q2, ready_d2, valid_q2;
  logic [1:0]  wb2;
  logic [2:0]  mem2;
  logic [3:0]  ex2;
  logic [31:0] d1_2, d2_2, ext2;
  logic [4:0]  rs2, rt2, rd2;
  logic [1:0]  occ2;
  logic [15:0] bub2;

  // 4-bit counter build, always idle with downstream ready
  logic        ready_d4, valid_q4;
  logic [1:0]  wb4;
  logic [2:0]  mem4;
  logic [3:0]  ex4;
  logic [31:0] d1_4, d2_4, ext4;
  logic [4:0]  rs4, rt4, rd4;
  logic [1:0]  occ4;
  logic [3:0]  bub4;

  int checks = 0;
  int errors = 0;
  id_ex_payload_t exp_q[$];

  id_ex_pipe_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d(valid_d), .ready_d(ready_d), .flush_i(flush),
    .wb_ctrl_d(drv.wb_ctrl), .mem_ctrl_d(drv.mem_ctrl), .ex_ctrl_d(drv.ex_ctrl),
    .data1_d(drv.data1), .data2_d(drv.data2), .extended_d(drv.extended),
    .rs_d(drv.rs), .rt_d(drv.rt), .rd_d(drv.rd),
    .valid_q(valid_q), .ready_q(ready_q),
    .wb_ctrl_q(wb_q), .mem_ctrl_q(mem_q), .ex_ctrl_q(ex_q),
    .data1_q(d1_q), .data2_q(d2_q), .extended_q(ext_q),
    .rs_q(rs_q), .rt_q(rt_q), .rd_q(rd_q), .occ_q(occ_q), .bubble_cnt_q(bub_q)
  );

  id_ex_pipe_stage #(.SKID_EN(1'b0)) dut_ns (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d(valid2), .ready_d(ready_d2), .flush_i(1'b0),
    .wb_ctrl_d(drv.wb_ctrl), .mem_ctrl_d(drv.mem_ctrl), .ex_ctrl_d(drv.ex_ctrl),
    .data1_d(drv.data1), .data2_d(drv.data2), .extended_d(drv.extended),
    .rs_d(drv.rs), .rt_d(drv.rt), .rd_d(drv.rd),
    .valid_q(valid_q2), .ready_q(ready_q2),
    .wb_ctrl_q(wb2), .mem_ctrl_q(mem2), .ex_ctrl_q(ex2),
    .data1_q(d1_2), .data2_q(d2_2), .extended_q(ext2),
    .rs_q(rs2), .rt_q(rt2), .rd_q(rd2), .occ_q(occ2), .bubble_cnt_q(bub2)
  );

  id_ex_pipe_stage #(.CNT_W(4)) dut_c4 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d(1'b0), .ready_d(ready_d4), .flush_i(1'b0),
    .wb_ctrl_d(drv.wb_ctrl), .mem_ctrl_d(drv.mem_ctrl), .ex_ctrl_d(drv.ex_ctrl),
    .data1_d(drv.data1), .data2_d(drv.data2), .extended_d(drv.extended),
    .rs_d(drv.rs), .rt_d(drv.rt), .rd_d(drv.rd),
    .valid_q(valid_q4), .ready_q(1'b1),
    .wb_ctrl_q(wb4), .mem_ctrl_q(mem4), .ex_ctrl_q(ex4),
    .data1_q(d1_4), .data2_q(d2_4), .extended_q(ext4),
    .rs_q(rs4), .rt_q(rt4), .rd_q(rd4), .occ_q(occ4), .bubble_cnt_q(bub4)
  );

  // State changes on the falling edge; the bench drives and samples between.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic id_ex_payload_t mk(input logic [7:0] k);
    id_ex_payload_t p;
    p.wb_ctrl  = 2'(k >> 4) | 2'b01;
    p.mem_ctrl = 3'(k) | 3'b100;
    p.ex_ctrl  = 4'(k >> 2) | 4'b1000;
    p.data1    = 32'(k);
    p.data2    = 32'(k) << 8;
    p.extended = 32'hFFFF_0000 | 32'(k);
    p.rs       = 5'(k);
    p.rt       = 5'(k + 8'd1);
    p.rd       = 5'(k + 8'd2);
    return p;
  endfunction

  // One cycle: drive at posedge+1, record acceptance at +3, return after the
  // falling edge so the caller can inspect the new state.
  task automatic cyc(input logic v, input logic [7:0] k, input logic f);
    @(posedge clk);
    #1;
    valid_d = v;
    drv     = mk(k);
    flush   = f;
    #2;
    if (v && ready_d && !f) exp_q.push_back(mk(k));
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops and compares every delivered entry, drops flushed entries,
  // and checks that an invalid main slot presents zero control.
  initial begin
    id_ex_payload_t e;
    forever begin
      @(posedge clk);
      #4;
      if (rst_n) begin
        if (valid_q && ready_q) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got %h expected nothing", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL sb_payload got %h expected %h", got, e);
            end
          end
        end
        if (flush) exp_q.delete();
        if (!valid_q) chk("bubble_ctrl", 64'({wb_q, mem_q, ex_q}), 64'd0);
      end
    end
  end

  initial begin
    id_ex_payload_t pf;
    rst_n = 1'b0; valid_d = 1'b0; flush = 1'b0; ready_q = 1'b1; drv = '0;
    valid2 = 1'b0; ready_q2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_q", 64'(valid_q), 64'd0);
    chk("rst_occ", 64'(occ_q), 64'd0);
    chk("rst_ready_d", 64'(ready_d), 64'd1);
    chk("rst_payload", 64'(got != '0), 64'd0);
    chk("rst_bubble", 64'(bub_q), 64'd0);
    rst_n = 1'b1;

    // idle with downstream ready
    repeat (5) @(negedge clk);
    #1;
    chk("idle_bubble5", 64'(bub_q), 64'd5);
    chk("idle_bubble5_c4", 64'(bub4), 64'd5);
    chk("idle_valid_q", 64'(valid_q), 64'd0);
    chk("idle_occ", 64'(occ_q), 64'd0);
    chk("idle_ready_d", 64'(ready_d), 64'd1);

    // streaming A,B,C
    cyc(1'b1, 8'h11, 1'b0);
    chk("strA_valid", 64'(valid_q), 64'd1);
    chk("strA_data1", 64'(d1_q), 64'h11);
    chk("strA_occ", 64'(occ_q), 64'd1);
    cyc(1'b1, 8'h22, 1'b0);
    chk("strB_data1", 64'(d1_q), 64'h22);
    chk("strB_occ", 64'(occ_q), 64'd1);
    cyc(1'b1, 8'h33, 1'b0);
    chk("strC_data1", 64'(d1_q), 64'h33);
    chk("strC_occ", 64'(occ_q), 64'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("str_drain_occ", 64'(occ_q), 64'd0);

    // stall: second entry lands in the skid
    ready_q = 1'b0;
    cyc(1'b1, 8'h41, 1'b0);
    cyc(1'b1, 8'h52, 1'b0);
    chk("stall_occ2", 64'(occ_q), 64'd2);
    chk("stall_ready_d", 64'(ready_d), 64'd0);
    chk("stall_hold_A", 64'(d1_q), 64'h41);
    cyc(1'b1, 8'h63, 1'b0);
    chk("stall_full_hold", 64'(d1_q), 64'h41);
    ready_q = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("release_occ1", 64'(occ_q), 64'd1);
    chk("release_ready_d", 64'(ready_d), 64'd1);
    chk("release_B", 64'(d1_q), 64'h52);
    cyc(1'b0, 8'h00, 1'b0);
    chk("release_occ0", 64'(occ_q), 64'd0);

    // flush with both entries held and a new entry offered
    ready_q = 1'b0;
    cyc(1'b1, 8'h71, 1'b0);
    cyc(1'b1, 8'h82, 1'b0);
    chk("preflush_occ2", 64'(occ_q), 64'd2);
    cyc(1'b1, 8'hD4, 1'b1);
    pf = mk(8'h71);
    chk("flush_valid_q", 64'(valid_q), 64'd0);
    chk("flush_occ", 64'(occ_q), 64'd0);
    chk("flush_ctrl", 64'({wb_q, mem_q, ex_q}), 64'd0);
    chk("flush_ready_d", 64'(ready_d), 64'd1);
    chk("flush_data_hold", 64'(d1_q), 64'(pf.data1));

    // flush while the head entry is being delivered
    cyc(1'b1, 8'h91, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0);
    ready_q = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("flushfire_occ", 64'(occ_q), 64'd0);
    chk("flushfire_sb", 64'(exp_q.size()), 64'd0);
    cyc(1'b0, 8'h00, 1'b0);

    // no-skid build: combinational ready, never more than one entry
    @(posedge clk);
    #1;
    drv = mk(8'hB5); valid2 = 1'b1; ready_q2 = 1'b1;
    @(negedge clk);
    #1;
    chk("ns_valid_q", 64'(valid_q2), 64'd1);
    chk("ns_data1", 64'(d1_2), 64'hB5);
    drv = mk(8'hC6);
    ready_q2 = 1'b0;
    #1;
    chk("ns_ready_low", 64'(ready_d2), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("ns_occ_max1", 64'(occ2), 64'd1);
    chk("ns_hold", 64'(d1_2), 64'hB5);
    valid2 = 1'b0;
    ready_q2 = 1'b1;
    #1;
    chk("ns_ready_high", 64'(ready_d2), 64'd1);
    @(negedge clk);
    #1;
    chk("ns_drain_occ", 64'(occ2), 64'd0);

    // 4-bit counter saturates instead of wrapping
    repeat (20) @(negedge clk);
    #1;
    chk("c4_saturate", 64'(bub4), 64'd15);

    // async reset in the middle of a full stall
    ready_q = 1'b0;
    cyc(1'b1, 8'hE1, 1'b0);
    cyc(1'b1, 8'hF2, 1'b0);
    chk("prerst_occ2", 64'(occ_q), 64'd2);
    valid_d = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid_q", 64'(valid_q), 64'd0);
    chk("arst_occ", 64'(occ_q), 64'd0);
    chk("arst_payload", 64'(got != '0), 64'd0);
    chk("arst_bubble", 64'(bub_q), 64'd0);
    chk("arst_ready_d", 64'(ready_d), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_q = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0);
    chk("postrst_data1", 64'(d1_q), 64'h5A);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
